// File: rtl/imem_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bundles the instruction-memory port, the redirect/halt control inputs, the
// decode-side valid/ready handshake and the fault report of imem_fetch_ctrl.
//
// Signals:
//   imem_addr      byte address presented to the instruction memory
//   imem_rdata     combinational read data for imem_addr
//   redirect_valid one-cycle redirect pulse (flush + PC reload)
//   redirect_pc    redirect target byte address
//   halt           level request to stop issuing fetches
//   instr_valid    head of the prefetch FIFO is valid
//   instr_ready    decode accepts the head
//   instr          head instruction word
//   instr_pc       head instruction byte address
//   fetch_fault    sticky fault flag
//   fault_pc       address that caused the fault
//
// Modports: master = fetch controller side, slave = memory/core side.
// -----------------------------------------------------------------------------
interface imem_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  modport master (
    output imem_addr, instr_valid, instr, instr_pc, fetch_fault, fault_pc,
    input  imem_rdata, redirect_valid, redirect_pc, halt, instr_ready
  );

  modport slave (
    input  imem_addr, instr_valid, instr, instr_pc, fetch_fault, fault_pc,
    output imem_rdata, redirect_valid, redirect_pc, halt, instr_ready
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Fetch sequencer for a single-cycle-read instruction memory. Owns the fetch
// PC, presents it as the memory address every cycle, captures {pc, word} into
// a small prefetch FIFO and hands the head to decode over valid/ready.
// Handles redirects (flush + PC reload), halt, and address faults
// (misaligned redirect target or fetch beyond the end of the ROM).
//
// Parameters:
//   RESET_PC    fetch PC loaded at reset
//   ROM_DEPTH   memory depth in 32-bit words (valid bytes 0 .. ROM_DEPTH*4-1)
//   FIFO_DEPTH  prefetch entries, power of two, >= 2
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        imem_fetch_ctrl_if.master (memory, redirect/halt, decode, fault)
//   perf_stall_cycles, perf_flushes  (only with FETCH_PERF_EN defined)
//
// Optional feature macro: FETCH_PERF_EN adds two 32-bit saturating counters:
// cycles where decode is ready but nothing is valid, and redirect pulses.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ROM_DEPTH  = 64,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  imem_fetch_ctrl_if.master       bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             perf_stall_cycles,
  output logic [31:0]             perf_flushes
`endif
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [31:0]       ROM_BYTES = 32'(ROM_DEPTH * 4);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic               fault_flag;
  logic [31:0]        fault_addr;

  logic [31:0]        fifo_pc   [FIFO_DEPTH];
  logic [31:0]        fifo_word [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic in_range;
  logic misaligned;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = !fifo_empty && bus.instr_ready;
  assign in_range   = (fetch_pc < ROM_BYTES);
  assign misaligned = (bus.redirect_pc[1:0] != 2'b00);

  // A full FIFO still accepts a word when the head leaves in the same cycle,
  // which is what sustains one instruction per cycle at FIFO_DEPTH entries.
  assign push = (state == RUN) && !bus.redirect_valid && in_range &&
                !bus.halt && (!fifo_full || pop);

  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? 32'h0 : fifo_word[rd_ptr];
  assign bus.instr_pc    = fifo_empty ? 32'h0 : fifo_pc[rd_ptr];
  assign bus.fetch_fault = fault_flag;
  assign bus.fault_pc    = fault_addr;

  // FIFO storage is data only: occupancy and pointers decide what is visible,
  // so stale entries never reach the outputs and need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= fetch_pc;
      fifo_word[wr_ptr] <= bus.imem_rdata;
    end
  end

  // Fetch state machine, PC and FIFO bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      fetch_pc   <= RESET_PC;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fault_flag <= 1'b0;
      fault_addr <= 32'h0;
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything; a same-cycle pop is simply absorbed
      // by the flush.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      if (misaligned) begin
        state      <= FAULT;
        fault_flag <= 1'b1;
        fault_addr <= bus.redirect_pc;
      end else begin
        fetch_pc   <= bus.redirect_pc;
        fault_flag <= 1'b0;
        state      <= (state == HALTED || bus.halt) ? HALTED : RUN;
      end
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        RUN: begin
          if (!in_range) begin
            state      <= FAULT;
            fault_flag <= 1'b1;
            fault_addr <= fetch_pc;
          end else if (bus.halt) begin
            state <= HALTED;
          end
        end
        HALTED: begin
          if (!bus.halt) begin
            state <= RUN;
          end
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  // Performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= 32'h0;
      perf_flushes      <= 32'h0;
    end else begin
      if (bus.instr_ready && fifo_empty) begin
        perf_stall_cycles <= sat_inc(perf_stall_cycles);
      end
      if (bus.redirect_valid) begin
        perf_flushes <= sat_inc(perf_flushes);
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic clk;
  logic rst_n;

  imem_fetch_ctrl_if bus_if ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
`endif

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .ROM_DEPTH  (64),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  // Memory model: word i holds A000_0000 + i.
  assign bus_if.imem_rdata = 32'hA000_0000 + (bus_if.imem_addr >> 2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  logic [31:0] sb [$];
  logic [31:0] frozen_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_run(input logic [31:0] start_pc, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start_pc + 32'(i * 4));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step(1);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: every accepted instruction is popped from the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.instr_valid && bus_if.instr_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_instr_pc", bus_if.instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          chk("instr_pc", bus_if.instr_pc, e);
          chk("instr", bus_if.instr, 32'hA000_0000 + (e >> 2));
        end
      end else if (!bus_if.instr_valid) begin
        chk("empty_instr", bus_if.instr, 64'd0);
        chk("empty_instr_pc", bus_if.instr_pc, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    bus_if.redirect_valid = 1'b0;
    bus_if.redirect_pc    = 32'h0;
    bus_if.halt           = 1'b0;
    bus_if.instr_ready    = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step(2);

    // Reset state
    chk("rst_valid", bus_if.instr_valid, 0);
    chk("rst_instr", bus_if.instr, 0);
    chk("rst_instr_pc", bus_if.instr_pc, 0);
    chk("rst_fault", bus_if.fetch_fault, 0);
    chk("rst_fault_pc", bus_if.fault_pc, 0);
    chk("rst_addr", bus_if.imem_addr, 0);

    expect_run(32'h0, 64);
    rst_n = 1'b1;
    #1 chk("valid_at_release", bus_if.instr_valid, 0);
    step(1);
    chk("valid_rise", bus_if.instr_valid, 1);
    chk("first_pc", bus_if.instr_pc, 0);
    step(2);

    // Backpressure: FIFO fills, fetch PC stops two words past the head
    bus_if.instr_ready = 1'b0;
    step(5);
    chk("stall_valid", bus_if.instr_valid, 1);
    chk("stall_head_pc", bus_if.instr_pc, 32'h8);
    chk("stall_addr", bus_if.imem_addr, 32'h10);
    bus_if.instr_ready = 1'b1;
    step(3);

    // Redirect while full: flushed entries must never appear
    bus_if.instr_ready = 1'b0;
    step(3);
    chk("full_valid", bus_if.instr_valid, 1);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h20;
    step(1);
    bus_if.redirect_valid = 1'b0;
    sb.delete();
    expect_run(32'h20, 56);
    chk("flush_valid", bus_if.instr_valid, 0);
    chk("redir_addr", bus_if.imem_addr, 32'h20);
    bus_if.instr_ready = 1'b1;
    step(5);

    // Halt mid-stream: FIFO drains, PC frozen, resumes where it stopped
    bus_if.halt = 1'b1;
    step(1);
    frozen_addr = bus_if.imem_addr;
    step(3);
    chk("halt_drained", bus_if.instr_valid, 0);
    chk("halt_pc_frozen", bus_if.imem_addr, frozen_addr);
    bus_if.halt = 1'b0;

    // Sequential run off the end of the ROM
    wait_drain("drain_to_rom_end", 200);
    step(2);
    chk("oor_fault", bus_if.fetch_fault, 1);
    chk("oor_fault_pc", bus_if.fault_pc, 32'h100);
    chk("oor_valid", bus_if.instr_valid, 0);
    chk("oor_addr", bus_if.imem_addr, 32'h100);

    // Misaligned redirect while faulted: fault_pc updates, PC unchanged
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h22;
    step(1);
    bus_if.redirect_valid = 1'b0;
    chk("mis_fault", bus_if.fetch_fault, 1);
    chk("mis_fault_pc", bus_if.fault_pc, 32'h22);
    chk("mis_addr", bus_if.imem_addr, 32'h100);
    step(2);
    chk("mis_valid", bus_if.instr_valid, 0);

    // Good redirect clears the fault and resumes
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h10;
    step(1);
    bus_if.redirect_valid = 1'b0;
    sb.delete();
    expect_run(32'h10, 60);
    chk("clear_fault", bus_if.fetch_fault, 0);
    chk("resume_addr", bus_if.imem_addr, 32'h10);
    step(6);

    // Reset mid-burst
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_valid", bus_if.instr_valid, 0);
    chk("midrst_addr", bus_if.imem_addr, 0);
    chk("midrst_fault", bus_if.fetch_fault, 0);
    step(2);
    expect_run(32'h0, 64);
    rst_n = 1'b1;
    step(1);
    chk("rerun_valid", bus_if.instr_valid, 1);
    chk("rerun_pc", bus_if.instr_pc, 0);
    step(3);

    // Misaligned redirect from RUN with a same-cycle pop
    frozen_addr = bus_if.imem_addr;
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h22;
    step(1);
    bus_if.redirect_valid = 1'b0;
    sb.delete();
    chk("run_mis_fault", bus_if.fetch_fault, 1);
    chk("run_mis_fault_pc", bus_if.fault_pc, 32'h22);
    chk("run_mis_addr", bus_if.imem_addr, frozen_addr);
    chk("run_mis_valid", bus_if.instr_valid, 0);
    step(3);
    chk("run_mis_quiet", bus_if.instr_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
